// File: rtl/text_pkg.sv
// Shared constants and encodings for the VGA text-buffer scheduler.
package text_pkg;

  // Text grid geometry: 80x30 cells of 8x16 pixels on a 640x480 display.
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  // Character written into every cell by a full-screen clear.
  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  // Visible area limits of the pixel/line counters.
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;

  // Command opcodes from the button front end.
  typedef enum logic [1:0] {
    OP_PUT     = 2'd0,
    OP_ADV     = 2'd1,
    OP_NEWLINE = 2'd2,
    OP_CLEAR   = 2'd3
  } cmd_op_e;

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/text_cursor.sv
// Cursor position register: column/row with advance, newline and home.
// Driven by one-cycle strobes; home beats newline beats advance.
module text_cursor #(
  parameter int N_COLS = 80,
  parameter int N_ROWS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  input  logic       newline_i,
  input  logic       home_i,
  output logic [6:0] col_o,
  output logic [4:0] row_o
);

  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       last_col, last_row;

  // Next cursor position from the strobes, wrapping the last cell back to (0,0).
  always_comb begin
    last_col = (col_q == 7'(N_COLS - 1));
    last_row = (row_q == 5'(N_ROWS - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (newline_i) begin
      col_d = '0;
      row_d = last_row ? '0 : row_q + 5'd1;
    end else if (adv_i) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 5'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  // Cursor registers, home position on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/text_buf_sched.sv
// Single-port character buffer scheduler: the display fetch owns every
// eighth visible pixel slot, cursor writes and screen clears use the rest.
module text_buf_sched #(
  parameter int         COLS       = text_pkg::COLS,
  parameter int         ROWS       = text_pkg::ROWS,
  parameter int         ADDR_W     = text_pkg::ADDR_W,
  parameter logic [7:0] CLEAR_CHAR = text_pkg::CLEAR_CHAR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_char,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  output logic              fetch_valid,
  output logic [6:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic              busy
);

  import text_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  // Row base address; the 80-column case uses two shifts instead of a multiplier.
  function automatic logic [ADDR_W-1:0] times_cols(input logic [ADDR_W-1:0] r);
    if (COLS == 80) begin
      return (r << 6) + (r << 4);
    end else begin
      return ADDR_W'(r * COLS);
    end
  endfunction

  state_e            state_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [7:0]        pend_data_q;
  logic [ADDR_W-1:0] clear_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [7:0]        ram_wdata_q;
  logic              fetch_valid_q;
  logic              cmd_ready_q;

  logic              fetch_slot;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] cursor_addr;
  cmd_op_e           op;
  logic              accept;
  logic              adv_stb;
  logic              newline_stb;
  logic              home_stb;
  logic [6:0]        col;
  logic [4:0]        row;

  // Slot arbitration, addresses and cursor strobes from the current counters and state.
  always_comb begin
    fetch_slot  = (counter_x < H_ACTIVE) && (counter_y < V_ACTIVE) &&
                  (counter_x[2:0] == 3'd0);
    fetch_addr  = times_cols(ADDR_W'(counter_y[9:4])) + ADDR_W'(counter_x[9:3]);
    cursor_addr = times_cols(ADDR_W'(row)) + ADDR_W'(col);
    op          = cmd_op_e'(cmd_op);
    accept      = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
    adv_stb     = (accept && (op == OP_ADV)) ||
                  ((state_q == ST_PEND) && !fetch_slot);
    newline_stb = accept && (op == OP_NEWLINE);
    home_stb    = (state_q == ST_CLEAR) && !fetch_slot && (clear_addr_q == LAST_ADDR);
  end

  // Control FSM with registered RAM port and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      clear_addr_q  <= '0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      fetch_valid_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      if (fetch_slot) begin
        ram_addr_q    <= fetch_addr;
        ram_we_q      <= 1'b0;
        fetch_valid_q <= 1'b1;
      end else if (state_q == ST_PEND) begin
        ram_addr_q    <= pend_addr_q;
        ram_wdata_q   <= pend_data_q;
        ram_we_q      <= 1'b1;
        fetch_valid_q <= 1'b0;
      end else if (state_q == ST_CLEAR) begin
        ram_addr_q    <= clear_addr_q;
        ram_wdata_q   <= CLEAR_CHAR;
        ram_we_q      <= 1'b1;
        fetch_valid_q <= 1'b0;
      end else begin
        ram_we_q      <= 1'b0;
        fetch_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            case (op)
              OP_PUT: begin
                pend_addr_q <= cursor_addr;
                pend_data_q <= cmd_char;
                state_q     <= ST_PEND;
                cmd_ready_q <= 1'b0;
              end
              OP_CLEAR: begin
                clear_addr_q <= '0;
                state_q      <= ST_CLEAR;
                cmd_ready_q  <= 1'b0;
              end
              OP_ADV, OP_NEWLINE: begin
                state_q <= ST_IDLE;
              end
            endcase
          end
        end
        ST_PEND: begin
          if (!fetch_slot) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!fetch_slot) begin
            if (clear_addr_q == LAST_ADDR) begin
              state_q     <= ST_IDLE;
              cmd_ready_q <= 1'b1;
            end else begin
              clear_addr_q <= clear_addr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  text_cursor #(
    .N_COLS (COLS),
    .N_ROWS (ROWS)
  ) u_cursor (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv_i     (adv_stb),
    .newline_i (newline_stb),
    .home_i    (home_stb),
    .col_o     (col),
    .row_o     (row)
  );

  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign fetch_valid = fetch_valid_q;
  assign cmd_ready   = cmd_ready_q;
  assign busy        = (state_q != ST_IDLE);
  assign cur_col     = col;
  assign cur_row     = row;

endmodule

// File: tb/tb_text_buf_sched.sv
// Bench for text_buf_sched: a queue-of-writes reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_text_buf_sched;

  localparam logic [1:0] C_PUT = 2'd0;
  localparam logic [1:0] C_ADV = 2'd1;
  localparam logic [1:0] C_NL  = 2'd2;
  localparam logic [1:0] C_CLR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  counter_x;
  logic [9:0]  counter_y;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_char;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic        fetch_valid;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  text_buf_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .counter_x   (counter_x),
    .counter_y   (counter_y),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_char    (cmd_char),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .fetch_valid (fetch_valid),
    .cur_col     (cur_col),
    .cur_row     (cur_row),
    .busy        (busy)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  // Count one comparison and report it when the values differ.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; they are sampled at the next rising edge.
  task automatic applyStimulus(input int x, input int y, input logic v,
                               input logic [1:0] op, input logic [7:0] ch);
    @(negedge clk);
    counter_x = 10'(x);
    counter_y = 10'(y);
    cmd_valid = v;
    cmd_op    = op;
    cmd_char  = ch;
  endtask

  // Wait past the next rising edge, after the model comparison has run.
  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Reference model: outstanding RAM writes kept as a queue in issue order.
  typedef struct {
    int addr;
    int data;
    int kind;   // 0 = character write, 1 = clear cell, 2 = final clear cell
  } wr_t;

  wr_t q[$];
  int  m_col, m_row, m_addr, m_data;
  bit  m_ready, m_we, m_fv;

  task automatic modelAdvance;
    if (m_col == 79) begin
      m_col = 0;
      m_row = (m_row == 29) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  // Model update at each rising edge, then compare all outputs just after it.
  always @(posedge clk) begin
    int  x, y;
    bit  acc;
    wr_t e;
    x = int'(counter_x);
    y = int'(counter_y);
    if (!rst_n) begin
      q.delete();
      m_col = 0; m_row = 0; m_addr = 0; m_data = 0;
      m_ready = 0; m_we = 0; m_fv = 0;
    end else begin
      acc = cmd_valid && m_ready;
      if (x < 640 && y < 480 && (x % 8) == 0) begin
        m_fv = 1; m_we = 0;
        m_addr = (y / 16) * 80 + x / 8;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_fv = 0; m_we = 1;
        m_addr = e.addr;
        m_data = e.data;
        if (e.kind == 0) modelAdvance();
        if (e.kind == 2) begin
          m_col = 0;
          m_row = 0;
        end
      end else begin
        m_fv = 0; m_we = 0;
      end
      if (acc) begin
        case (cmd_op)
          C_PUT: begin
            e.addr = m_row * 80 + m_col;
            e.data = int'(cmd_char);
            e.kind = 0;
            q.push_back(e);
          end
          C_ADV: modelAdvance();
          C_NL: begin
            m_col = 0;
            m_row = (m_row == 29) ? 0 : m_row + 1;
          end
          default: begin
            for (int a = 0; a < 2400; a++) begin
              e.addr = a;
              e.data = 32;
              e.kind = (a == 2399) ? 2 : 1;
              q.push_back(e);
            end
          end
        endcase
      end
      m_ready = (q.size() == 0);
    end
    #1;
    checkOutput("ram_we", int'(ram_we), int'(m_we));
    checkOutput("fetch_valid", int'(fetch_valid), int'(m_fv));
    checkOutput("ram_addr", int'(ram_addr), m_addr);
    checkOutput("ram_wdata", int'(ram_wdata), m_data);
    checkOutput("cur_col", int'(cur_col), m_col);
    checkOutput("cur_row", int'(cur_row), m_row);
    checkOutput("cmd_ready", int'(cmd_ready), int'(m_ready && rst_n));
    checkOutput("busy", int'(busy), int'(q.size() > 0));
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int x, y, wr, fc, lastAddr, badData, cnt;
    rst_n     = 1'b0;
    counter_x = 10'd16;
    counter_y = 10'd32;
    cmd_valid = 1'b0;
    cmd_op    = C_PUT;
    cmd_char  = 8'h00;

    // Reset held mid-frame on a fetch slot: everything stays at reset values.
    repeat (3) settle();
    checkOutput("rst_we", int'(ram_we), 0);
    checkOutput("rst_fv", int'(fetch_valid), 0);
    checkOutput("rst_addr", int'(ram_addr), 0);
    checkOutput("rst_ready", int'(cmd_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", int'(cmd_ready), 0);
    settle();
    checkOutput("ready_after_edge", int'(cmd_ready), 1);

    // PUT 'A' during blanking: written to address 0 one edge after acceptance.
    applyStimulus(700, 0, 1'b1, C_PUT, 8'h41);
    applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("putA_we", int'(ram_we), 1);
    checkOutput("putA_addr", int'(ram_addr), 0);
    checkOutput("putA_data", int'(ram_wdata), 8'h41);
    checkOutput("putA_col", int'(cur_col), 1);

    // PUT colliding with a fetch slot: fetch of cell 1 first, write one cycle later.
    applyStimulus(700, 0, 1'b1, C_PUT, 8'h42);
    applyStimulus(8, 0, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("coll_fv", int'(fetch_valid), 1);
    checkOutput("coll_we0", int'(ram_we), 0);
    checkOutput("coll_faddr", int'(ram_addr), 1);
    checkOutput("coll_col0", int'(cur_col), 1);
    applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("coll_we1", int'(ram_we), 1);
    checkOutput("coll_waddr", int'(ram_addr), 1);
    checkOutput("coll_data", int'(ram_wdata), 8'h42);
    checkOutput("coll_col1", int'(cur_col), 2);

    // Last visible fetch slot maps to the last cell.
    applyStimulus(632, 479, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("last_fetch_fv", int'(fetch_valid), 1);
    checkOutput("last_fetch_addr", int'(ram_addr), 2399);

    // Walk the cursor to (79,29), then PUT wraps it to (0,0).
    for (int i = 0; i < 29; i++) applyStimulus(700, 0, 1'b1, C_NL, 8'h00);
    for (int i = 0; i < 79; i++) applyStimulus(700, 0, 1'b1, C_ADV, 8'h00);
    applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("walk_col", int'(cur_col), 79);
    checkOutput("walk_row", int'(cur_row), 29);
    applyStimulus(700, 0, 1'b1, C_PUT, 8'h5A);
    applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("wrap_addr", int'(ram_addr), 2399);
    checkOutput("wrap_data", int'(ram_wdata), 8'h5A);
    checkOutput("wrap_col", int'(cur_col), 0);
    checkOutput("wrap_row", int'(cur_row), 0);

    // NEWLINE on the last row wraps to the top.
    for (int i = 0; i < 29; i++) applyStimulus(700, 0, 1'b1, C_NL, 8'h00);
    applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("nl_row29", int'(cur_row), 29);
    applyStimulus(700, 0, 1'b1, C_NL, 8'h00);
    applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
    settle();
    checkOutput("nl_wrap_col", int'(cur_col), 0);
    checkOutput("nl_wrap_row", int'(cur_row), 0);

    // CLEAR started at the top of a frame with counters running.
    for (int i = 0; i < 3; i++) applyStimulus(700, 0, 1'b1, C_ADV, 8'h00);
    x = 0; y = 0; wr = 0; fc = 0; lastAddr = -1; badData = 0;
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(x, y, (i == 0), C_CLR, 8'h00);
      settle();
      if (ram_we) begin
        if (int'(ram_addr) != lastAddr + 1 || ram_wdata != 8'h20) badData++;
        lastAddr = int'(ram_addr);
        wr++;
      end
      if (fetch_valid) fc++;
      x++;
      if (x == 800) begin
        x = 0;
        y++;
      end
    end
    checkOutput("clr_writes", wr, 2400);
    checkOutput("clr_order", badData, 0);
    checkOutput("clr_last", lastAddr, 2399);
    checkOutput("clr_fetches", fc, 400);
    checkOutput("clr_col", int'(cur_col), 0);
    checkOutput("clr_row", int'(cur_row), 0);
    checkOutput("clr_busy", int'(busy), 0);

    // Reset after 100 CLEAR writes aborts the clear.
    applyStimulus(700, 0, 1'b1, C_CLR, 8'h00);
    cnt = 0;
    for (int i = 0; i < 300 && cnt < 100; i++) begin
      applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
      settle();
      if (ram_we) cnt++;
    end
    checkOutput("abort_count", cnt, 100);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we", int'(ram_we), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_ready", int'(cmd_ready), 0);
    repeat (2) settle();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(700, 0, 1'b0, C_PUT, 8'h00);
      settle();
      if (ram_we) cnt++;
    end
    checkOutput("post_abort_writes", cnt, 0);
    checkOutput("post_abort_ready", int'(cmd_ready), 1);
    checkOutput("post_abort_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
